// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - round-robin write arbiter with locked bursts for a load-enable register bank
//
// Purpose: shares the write path of an NREGS x DW register bank among NREQ
//   requesters. Arbitration is round-robin. A requester may lock ownership
//   for up to MAXBURST back-to-back writes. The load strobes and data to the
//   bank are registered. A saturating counter records contention cycles.
//
// Ports:
//   clk            clock, rising edge
//   rst            asynchronous active-high reset
//   en             global enable; 0 freezes arbitration and ends any burst
//   req_valid      per-requester write request
//   req_lock       per-requester request to keep ownership next cycle
//   req_addr       packed register indices, requester i at [i*AW +: AW]
//   req_data       packed write data, requester i at [i*DW +: DW]
//   req_ready      one-hot combinational accept
//   reg_load       one-hot registered load strobes to the bank
//   reg_d          registered data to the bank
//   gnt_valid      registered; high while reg_load is non-zero
//   gnt_id         registered index of the requester owning reg_load
//   contention_cnt saturating count of enabled cycles with >=2 requests

module reg_write_arbiter #(
  parameter int NREQ     = 4,
  parameter int NREGS    = 8,
  parameter int AW       = $clog2(NREGS),
  parameter int DW       = 32,
  parameter int MAXBURST = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ-1:0]         req_lock,
  input  logic [NREQ*AW-1:0]      req_addr,
  input  logic [NREQ*DW-1:0]      req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic [NREGS-1:0]        reg_load,
  output logic [DW-1:0]           reg_d,
  output logic                    gnt_valid,
  output logic [$clog2(NREQ)-1:0] gnt_id,
  output logic [15:0]             contention_cnt
);

  localparam int IW = $clog2(NREQ);
  localparam int BW = $clog2(MAXBURST + 1);
  // burst_cnt value at which the next accept is the last one of the burst
  localparam logic [BW-1:0] BURST_LAST = BW'(MAXBURST - 1);

  typedef enum logic [0:0] {
    ST_ARB   = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [BW-1:0]   burst_cnt_q, burst_cnt_d;

  logic [NREGS-1:0] reg_load_q;
  logic [DW-1:0]    reg_d_q;
  logic             gnt_valid_q;
  logic [IW-1:0]    gnt_id_q;
  logic [15:0]      contention_q;

  logic [AW-1:0]    addr_arr [NREQ];
  logic [DW-1:0]    data_arr [NREQ];
  logic [IW-1:0]    search_idx;
  logic [IW-1:0]    win_id;
  logic             win_found;
  logic [IW-1:0]    sel_id;
  logic             accept;
  logic [NREGS-1:0] load_vec;

  // Increment modulo NREQ; NREQ need not be a power of two.
  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    if (i == IW'(NREQ - 1)) begin
      return '0;
    end
    return i + 1'b1;
  endfunction

  // Unpack the flat request buses so they can be indexed by requester id.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      addr_arr[i] = req_addr[i*AW +: AW];
      data_arr[i] = req_data[i*DW +: DW];
    end
  end

  // Round-robin search: walk NREQ slots starting at rr_ptr, take the first valid.
  always_comb begin
    win_found  = 1'b0;
    win_id     = '0;
    search_idx = rr_ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      if (!win_found && req_valid[search_idx]) begin
        win_found = 1'b1;
        win_id    = search_idx;
      end
      search_idx = next_idx(search_idx);
    end
  end

  // Ready generation and next-state logic.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    req_ready   = '0;
    sel_id      = (state_q == ST_ARB) ? win_id : owner_q;

    if (!rst && en) begin
      if (state_q == ST_ARB) begin
        if (win_found) begin
          req_ready[win_id] = 1'b1;
        end
      end else if (req_valid[owner_q]) begin
        req_ready[owner_q] = 1'b1;
      end
    end

    accept = |(req_ready & req_valid);

    case (state_q)
      ST_ARB: begin
        if (accept) begin
          if (req_lock[sel_id] && (MAXBURST > 1)) begin
            // rr_ptr stays put; it advances past the owner when the burst ends
            state_d     = ST_BURST;
            owner_d     = sel_id;
            burst_cnt_d = BW'(1);
          end else begin
            rr_ptr_d = next_idx(sel_id);
          end
        end
      end
      ST_BURST: begin
        // No accept covers both en=0 and the owner dropping its request.
        if (!accept || !req_lock[owner_q] || (burst_cnt_q >= BURST_LAST)) begin
          state_d     = ST_ARB;
          rr_ptr_d    = next_idx(owner_q);
          burst_cnt_d = '0;
        end else begin
          burst_cnt_d = burst_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_ARB;
      end
    endcase
  end

  always_comb begin
    load_vec = '0;
    load_vec[addr_arr[sel_id]] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_ARB;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      burst_cnt_q  <= '0;
      reg_load_q   <= '0;
      reg_d_q      <= '0;
      gnt_valid_q  <= 1'b0;
      gnt_id_q     <= '0;
      contention_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;

      if (accept) begin
        reg_load_q  <= load_vec;
        reg_d_q     <= data_arr[sel_id];
        gnt_valid_q <= 1'b1;
        gnt_id_q    <= sel_id;
      end else begin
        // reg_d and gnt_id keep the last granted values
        reg_load_q  <= '0;
        gnt_valid_q <= 1'b0;
      end

      if (en && ($countones(req_valid) >= 2) && (contention_q != 16'hFFFF)) begin
        contention_q <= contention_q + 16'd1;
      end
    end
  end

  assign reg_load       = reg_load_q;
  assign reg_d          = reg_d_q;
  assign gnt_valid      = gnt_valid_q;
  assign gnt_id         = gnt_id_q;
  assign contention_cnt = contention_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb/tb_reg_write_arbiter.sv - directed self-checking bench for reg_write_arbiter

module tb_reg_write_arbiter;

  logic         clk;
  logic         rst;
  logic         en;
  logic [3:0]   req_valid;
  logic [3:0]   req_lock;
  logic [11:0]  req_addr;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic [7:0]   reg_load;
  logic [31:0]  reg_d;
  logic         gnt_valid;
  logic [1:0]   gnt_id;
  logic [15:0]  contention_cnt;

  int compares;
  int errors;

  reg_write_arbiter #(
    .NREQ(4), .NREGS(8), .AW(3), .DW(32), .MAXBURST(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .req_valid(req_valid),
    .req_lock(req_lock),
    .req_addr(req_addr),
    .req_data(req_data),
    .req_ready(req_ready),
    .reg_load(reg_load),
    .reg_d(reg_d),
    .gnt_valid(gnt_valid),
    .gnt_id(gnt_id),
    .contention_cnt(contention_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_req(input int i, input logic v, input logic l,
                         input logic [2:0] a, input logic [31:0] d);
    req_valid[i]         = v;
    req_lock[i]          = l;
    req_addr[i*3 +: 3]   = a;
    req_data[i*32 +: 32] = d;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_lock  = '0;
  endtask

  // Returns at posedge+1 with rst released.
  task automatic do_reset();
    clear_reqs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b0, 3'(i), 32'h100 + i);
    repeat (2) @(posedge clk);
    #1;
    compares++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected %b", req_ready, 4'b0000); end
    compares++; if (reg_load !== 8'h00) begin errors++; $display("FAIL reset_load: got %h expected %h", reg_load, 8'h00); end
    compares++; if (reg_d !== 32'h0) begin errors++; $display("FAIL reset_d: got %h expected %h", reg_d, 32'h0); end
    compares++; if (contention_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt: got %h expected %h", contention_cnt, 16'h0); end
    compares++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL reset_gv: got %b expected %b", gnt_valid, 1'b0); end
    rst = 1'b0;
    #1;
    compares++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_ready: got %b expected %b", req_ready, 4'b0001); end
    @(posedge clk); #1;
    compares++; if (gnt_id !== 2'd0 || gnt_valid !== 1'b1) begin errors++; $display("FAIL reset_first_gnt: got id %0d v %b expected id 0 v 1", gnt_id, gnt_valid); end
    compares++; if (contention_cnt !== 16'd1) begin errors++; $display("FAIL reset_first_cnt: got %0d expected 1", contention_cnt); end
    clear_reqs();
  endtask

  task automatic test_single();
    do_reset();
    en = 1'b1;
    set_req(2, 1'b1, 1'b0, 3'd5, 32'hDEADBEEF);
    #1;
    compares++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b expected %b", req_ready, 4'b0100); end
    @(posedge clk); #1;
    clear_reqs();
    compares++; if (reg_load !== 8'b0010_0000) begin errors++; $display("FAIL single_load: got %b expected %b", reg_load, 8'b0010_0000); end
    compares++; if (reg_d !== 32'hDEADBEEF) begin errors++; $display("FAIL single_d: got %h expected %h", reg_d, 32'hDEADBEEF); end
    compares++; if (gnt_id !== 2'd2 || gnt_valid !== 1'b1) begin errors++; $display("FAIL single_gnt: got id %0d v %b expected id 2 v 1", gnt_id, gnt_valid); end
    @(posedge clk); #1;
    compares++; if (reg_load !== 8'h00 || gnt_valid !== 1'b0) begin errors++; $display("FAIL single_idle: got load %h v %b expected load 00 v 0", reg_load, gnt_valid); end
    compares++; if (reg_d !== 32'hDEADBEEF) begin errors++; $display("FAIL single_hold_d: got %h expected %h", reg_d, 32'hDEADBEEF); end
    compares++; if (contention_cnt !== 16'd0) begin errors++; $display("FAIL single_cnt: got %0d expected 0", contention_cnt); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_r;
    logic [7:0] exp_l;
    int         id;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b0, 3'(i), 32'hA0 + i);
    for (int k = 0; k < 6; k++) begin
      if (k >= 1) begin
        id    = (k - 1) % 4;
        exp_l = 8'b0000_0001 << id;
        compares++; if (gnt_id !== 2'(id)) begin errors++; $display("FAIL rr_gnt_id%0d: got %0d expected %0d", k, gnt_id, id); end
        compares++; if (reg_load !== exp_l) begin errors++; $display("FAIL rr_load%0d: got %b expected %b", k, reg_load, exp_l); end
        compares++; if (reg_d !== 32'hA0 + id) begin errors++; $display("FAIL rr_d%0d: got %h expected %h", k, reg_d, 32'hA0 + id); end
        compares++; if (contention_cnt !== 16'(k)) begin errors++; $display("FAIL rr_cnt%0d: got %0d expected %0d", k, contention_cnt, k); end
      end
      if (k == 5) clear_reqs();
      #1;
      if (k < 5) begin
        exp_r = 4'b0001 << (k % 4);
        compares++; if (req_ready !== exp_r) begin errors++; $display("FAIL rr_ready%0d: got %b expected %b", k, req_ready, exp_r); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_burst_limit();
    int         exp_ids [5];
    logic [3:0] exp_r;
    logic [7:0] exp_l;
    exp_ids = '{1, 1, 1, 1, 3};
    do_reset();
    en = 1'b1;
    set_req(1, 1'b1, 1'b1, 3'd6, 32'h1111_0001);
    set_req(3, 1'b1, 1'b0, 3'd2, 32'h3333_0003);
    for (int k = 0; k < 6; k++) begin
      if (k >= 1) begin
        exp_l = (exp_ids[k-1] == 1) ? 8'h40 : 8'h04;
        compares++; if (gnt_id !== 2'(exp_ids[k-1])) begin errors++; $display("FAIL burst_gnt_id%0d: got %0d expected %0d", k, gnt_id, exp_ids[k-1]); end
        compares++; if (reg_load !== exp_l) begin errors++; $display("FAIL burst_load%0d: got %h expected %h", k, reg_load, exp_l); end
      end
      if (k == 5) begin
        compares++; if (contention_cnt !== 16'd5) begin errors++; $display("FAIL burst_cnt: got %0d expected 5", contention_cnt); end
        clear_reqs();
      end
      #1;
      if (k < 5) begin
        exp_r = 4'b0001 << exp_ids[k];
        compares++; if (req_ready !== exp_r) begin errors++; $display("FAIL burst_ready%0d: got %b expected %b", k, req_ready, exp_r); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_en_freeze();
    do_reset();
    en = 1'b1;
    set_req(0, 1'b1, 1'b1, 3'd0, 32'h0000_F000);
    set_req(2, 1'b1, 1'b0, 3'd4, 32'h0000_F002);
    #1;
    compares++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL freeze_ready0: got %b expected %b", req_ready, 4'b0001); end
    @(posedge clk); #1;
    compares++; if (reg_load !== 8'h01 || gnt_id !== 2'd0) begin errors++; $display("FAIL freeze_first_gnt: got load %h id %0d expected load 01 id 0", reg_load, gnt_id); end
    en = 1'b0;
    for (int j = 0; j < 3; j++) begin
      #1;
      compares++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL freeze_ready_off%0d: got %b expected %b", j, req_ready, 4'b0000); end
      @(posedge clk); #1;
      compares++; if (reg_load !== 8'h00 || gnt_valid !== 1'b0) begin errors++; $display("FAIL freeze_load_off%0d: got load %h v %b expected 00 v 0", j, reg_load, gnt_valid); end
      compares++; if (contention_cnt !== 16'd1) begin errors++; $display("FAIL freeze_cnt%0d: got %0d expected 1", j, contention_cnt); end
    end
    en = 1'b1;
    #1;
    compares++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL freeze_resume_ready: got %b expected %b", req_ready, 4'b0100); end
    @(posedge clk); #1;
    clear_reqs();
    compares++; if (gnt_id !== 2'd2 || reg_load !== 8'h10) begin errors++; $display("FAIL freeze_resume_gnt: got id %0d load %h expected id 2 load 10", gnt_id, reg_load); end
    compares++; if (contention_cnt !== 16'd2) begin errors++; $display("FAIL freeze_resume_cnt: got %0d expected 2", contention_cnt); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    en = 1'b1;
    set_req(1, 1'b1, 1'b1, 3'd3, 32'h5555_0001);
    set_req(2, 1'b1, 1'b0, 3'd7, 32'h5555_0002);
    #1;
    compares++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL midrst_ready: got %b expected %b", req_ready, 4'b0010); end
    @(posedge clk); #1;
    compares++; if (reg_load !== 8'h08) begin errors++; $display("FAIL midrst_load: got %h expected %h", reg_load, 8'h08); end
    #2;
    rst = 1'b1;
    #1;
    compares++; if (reg_load !== 8'h00 || gnt_valid !== 1'b0) begin errors++; $display("FAIL midrst_drop: got load %h v %b expected 00 v 0", reg_load, gnt_valid); end
    compares++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL midrst_ready_off: got %b expected %b", req_ready, 4'b0000); end
    @(posedge clk); #1;
    rst = 1'b0;
    set_req(0, 1'b1, 1'b0, 3'd1, 32'h5555_0000);
    compares++; if (reg_load !== 8'h00) begin errors++; $display("FAIL midrst_no_strobe: got %h expected %h", reg_load, 8'h00); end
    #1;
    compares++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL midrst_restart_ready: got %b expected %b", req_ready, 4'b0001); end
    @(posedge clk); #1;
    clear_reqs();
    compares++; if (gnt_id !== 2'd0 || reg_load !== 8'h02) begin errors++; $display("FAIL midrst_restart_gnt: got id %0d load %h expected id 0 load 02", gnt_id, reg_load); end
  endtask

  initial begin
    compares  = 0;
    errors    = 0;
    rst       = 1'b1;
    en        = 1'b0;
    req_valid = '0;
    req_lock  = '0;
    req_addr  = '0;
    req_data  = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_burst_limit();
    test_en_freeze();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
    $finish;
  end

endmodule
